// File: rtl/sv_audio_dma.sv
// Audio DMA sample reader: fetches packed 4-bit PCM bytes from ROM and plays the nibbles, high then low,
// every BASE_DIV<<rate clocks; pulses done when a block finishes on its own.
module sv_audio_dma #(
  parameter int unsigned BASE_DIV = 3200
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dma_addr,
  input  logic [7:0]  dma_length,
  input  logic [7:0]  dma_ctrl,
  input  logic        trig_we,
  input  logic [7:0]  trig_data,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [2:0]  mem_bank,
  input  logic        mem_ack,
  input  logic [7:0]  mem_data,
  output logic [3:0]  sample,
  output logic        sample_stb,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, REQ, PLAY} state_t;

  state_t      state_q;
  logic [15:0] addr_q;
  logic [12:0] left_q;
  logic [1:0]  rate_q;
  logic [2:0]  bank_q;
  logic [14:0] cnt_q;
  logic [7:0]  buf_q;
  logic        buf_vld_q;
  logic [3:0]  cur_lo_q;
  logic        half_q;
  logic        stale_q;
  logic [3:0]  sample_q;

  logic        active;
  logic        start;
  logic        stop;
  logic        ack_ok;
  logic        tick;
  logic        emit_lo;
  logic        emit_hi;
  logic        emit;
  logic        last;
  logic [3:0]  nib_d;
  logic [12:0] bytes_d;
  logic        unused_bits;

  function automatic logic [14:0] period_m1(input logic [1:0] r);
    period_m1 = 15'((BASE_DIV << r) - 1);
  endfunction

  assign active  = (state_q != IDLE);
  assign start   = trig_we && trig_data[7] && dma_ctrl[7];
  assign stop    = trig_we && !trig_data[7] && active;
  assign ack_ok  = (state_q == REQ) && mem_ack && !stale_q;
  assign tick    = active && (cnt_q == 15'd0);
  // half_q = 1 means the current byte is used up (or none loaded yet)
  assign emit_lo = tick && !half_q;
  assign emit_hi = tick && half_q && buf_vld_q;
  assign emit    = (emit_lo || emit_hi) && !start && !stop;
  assign last    = emit_lo && (left_q == 13'd0) && !buf_vld_q;
  assign nib_d   = emit_lo ? cur_lo_q : buf_q[7:4];
  assign bytes_d = {dma_length == 8'd0, dma_length, 4'b0000};

  assign mem_req    = (state_q == REQ);
  assign mem_addr   = addr_q;
  assign mem_bank   = bank_q;
  assign busy       = active;
  assign sample     = emit ? nib_d : sample_q;
  assign sample_stb = emit;
  assign done       = emit && last;

  assign unused_bits = ^{dma_ctrl[3:2], trig_data[6:0]};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      addr_q    <= 16'd0;
      left_q    <= 13'd0;
      rate_q    <= 2'd0;
      bank_q    <= 3'd0;
      cnt_q     <= 15'd0;
      buf_q     <= 8'd0;
      buf_vld_q <= 1'b0;
      cur_lo_q  <= 4'd0;
      half_q    <= 1'b1;
      stale_q   <= 1'b0;
      sample_q  <= 4'd0;
    end else begin
      if (mem_ack) stale_q <= 1'b0;
      if (start) begin
        state_q   <= REQ;
        addr_q    <= dma_addr;
        left_q    <= bytes_d;
        rate_q    <= dma_ctrl[1:0];
        bank_q    <= dma_ctrl[6:4];
        cnt_q     <= period_m1(dma_ctrl[1:0]);
        buf_vld_q <= 1'b0;
        half_q    <= 1'b1;
        // the request still in flight will be answered once; that answer belongs to the old epoch
        stale_q   <= mem_req && !mem_ack;
      end else if (stop) begin
        state_q <= IDLE;
        stale_q <= mem_req && !mem_ack;
      end else if (active) begin
        if (cnt_q != 15'd0) cnt_q <= cnt_q - 15'd1;
        else if (emit)      cnt_q <= period_m1(rate_q);
        if (ack_ok) begin
          buf_q     <= mem_data;
          buf_vld_q <= 1'b1;
          addr_q    <= addr_q + 16'd1;
          left_q    <= left_q - 13'd1;
          state_q   <= PLAY;
        end
        if (emit_lo) half_q <= 1'b1;
        if (emit_hi) begin
          cur_lo_q  <= buf_q[3:0];
          half_q    <= 1'b0;
          buf_vld_q <= 1'b0;
          if (left_q != 13'd0) state_q <= REQ;
        end
        if (emit) sample_q <= nib_d;
        if (last) state_q <= IDLE;
      end
    end
  end

endmodule

// File: tb/tb_sv_audio_dma.sv
// Bench for sv_audio_dma: table of block scenarios plus random blocks, checked against a
// sample-order / strobe-timing model, and hand-written stop and restart sequences.
module tb_sv_audio_dma;

  localparam int unsigned DIV = 4;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] dma_addr;
  logic [7:0]  dma_length;
  logic [7:0]  dma_ctrl;
  logic        trig_we;
  logic [7:0]  trig_data;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [2:0]  mem_bank;
  logic        mem_ack;
  logic [7:0]  mem_data;
  logic [3:0]  sample;
  logic        sample_stb;
  logic        busy;
  logic        done;

  sv_audio_dma #(.BASE_DIV(DIV)) dut (
    .clk(clk), .reset(reset), .dma_addr(dma_addr), .dma_length(dma_length),
    .dma_ctrl(dma_ctrl), .trig_we(trig_we), .trig_data(trig_data),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_bank(mem_bank),
    .mem_ack(mem_ack), .mem_data(mem_data), .sample(sample),
    .sample_stb(sample_stb), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  // ROM model: one outstanding job per request, ack after a chosen delay
  logic [7:0]  mem_arr [0:65535];
  int          mem_delay = 2;
  bit          rand_delay = 1'b0;
  int          stall_idx = -1;
  int          stall_len = 0;
  bit          job_active = 1'b0;
  int          job_cnt;
  logic [15:0] job_addr;
  logic [15:0] req_addr_q [$];
  logic [2:0]  req_bank_q [$];
  int          ack_cyc_q [$];

  initial begin
    mem_ack  = 1'b0;
    mem_data = 8'd0;
    forever begin
      @(posedge clk); #1;
      mem_ack = 1'b0;
      if (job_active) begin
        if (job_cnt <= 1) begin
          mem_ack    = 1'b1;
          mem_data   = mem_arr[job_addr];
          job_active = 1'b0;
          ack_cyc_q.push_back(cyc);
        end else job_cnt--;
      end else if (mem_req === 1'b1) begin
        job_active = 1'b1;
        job_addr   = mem_addr;
        req_addr_q.push_back(mem_addr);
        req_bank_q.push_back(mem_bank);
        job_cnt = rand_delay ? int'($urandom_range(1, 3)) : mem_delay;
        if (req_addr_q.size() - 1 == stall_idx) job_cnt = stall_len;
      end
    end
  end

  int          stb_cyc_q [$];
  logic [3:0]  smp_q [$];
  int          done_cyc_q [$];

  always @(negedge clk) begin
    if (sample_stb === 1'b1) begin
      stb_cyc_q.push_back(cyc);
      smp_q.push_back(sample);
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  ctrl;
    int          pat;          // 0: byte i = i*0x11, 1: random
    int          stall_idx;
    int          stall_len;
    int          exp_strobes;
    int          exp_period;
    int          exp_bank;
  } vec_t;

  task automatic clear_logs();
    req_addr_q.delete(); req_bank_q.delete(); ack_cyc_q.delete();
    stb_cyc_q.delete(); smp_q.delete(); done_cyc_q.delete();
  endtask

  task automatic do_trig(input logic [7:0] d, output int n);
    @(posedge clk); #1;
    n = cyc;
    trig_data = d;
    trig_we   = 1'b1;
    @(posedge clk); #1;
    trig_we   = 1'b0;
  endtask

  task automatic wait_mem_idle();
    for (int i = 0; i < 400 && job_active; i++) @(posedge clk);
    #1;
  endtask

  task automatic run_block(input vec_t v, input string tag);
    int nbytes, n, prev, t, m, bi, ix, budget;
    int exp_t [$];
    logic [7:0] b;
    logic [3:0] e;

    nbytes = (v.len == 8'd0) ? 4096 : int'(v.len) * 16;
    if (!v.ctrl[7]) nbytes = 0;
    for (int i = 0; i < nbytes; i++)
      mem_arr[16'(v.addr + i)] = (v.pat == 0) ? 8'((i * 17) & 255) : 8'($urandom);
    stall_idx = v.stall_idx;
    stall_len = v.stall_len;
    clear_logs();
    dma_addr = v.addr; dma_length = v.len; dma_ctrl = v.ctrl;
    do_trig(8'h80, n);
    @(negedge clk);
    chk({tag, " busy_after_trig"}, busy, v.ctrl[7]);

    budget = v.exp_strobes * (v.exp_period + 2) + v.stall_len + 200;
    for (int i = 0; i < budget; i++) begin
      if (done_cyc_q.size() > 0 || !busy) break;
      @(negedge clk);
    end
    if (v.ctrl[7]) begin
      @(negedge clk);
      chk({tag, " busy_after_done"}, busy, 0);
    end
    repeat (20) @(negedge clk);

    chk({tag, " strobe_count"}, stb_cyc_q.size(), v.exp_strobes);
    chk({tag, " done_count"}, done_cyc_q.size(), (v.exp_strobes > 0) ? 1 : 0);
    chk({tag, " req_count"}, req_addr_q.size(), nbytes);
    if (nbytes == 0) return;

    m = (req_addr_q.size() < nbytes) ? req_addr_q.size() : nbytes;
    if (m > 0) begin
      bi = -1;
      for (int i = 0; i < m; i++) if (bi < 0 && req_addr_q[i] != 16'(v.addr + i)) bi = i;
      ix = (bi < 0) ? m - 1 : bi;
      chk($sformatf("%s req_addr[%0d]", tag, ix), req_addr_q[ix], 16'(v.addr + ix));
      bi = -1;
      for (int i = 0; i < m; i++) if (bi < 0 && req_bank_q[i] != 3'(v.exp_bank)) bi = i;
      ix = (bi < 0) ? m - 1 : bi;
      chk($sformatf("%s req_bank[%0d]", tag, ix), req_bank_q[ix], v.exp_bank);
    end

    // model: nibbles high then low per byte; strobe k = max(prev + period, data arrival + 1)
    prev = n;
    for (int k = 0; k < v.exp_strobes; k++) begin
      t = prev + v.exp_period;
      if (k % 2 == 0 && k / 2 < ack_cyc_q.size() && ack_cyc_q[k / 2] + 1 > t) t = ack_cyc_q[k / 2] + 1;
      exp_t.push_back(t);
      prev = t;
    end
    m = (smp_q.size() < v.exp_strobes) ? smp_q.size() : v.exp_strobes;
    if (m == 0) return;
    bi = -1;
    for (int k = 0; k < m; k++) begin
      b = mem_arr[16'(v.addr + k / 2)];
      e = (k % 2 == 0) ? b[7:4] : b[3:0];
      if (bi < 0 && smp_q[k] != e) bi = k;
    end
    ix = (bi < 0) ? m - 1 : bi;
    b = mem_arr[16'(v.addr + ix / 2)];
    e = (ix % 2 == 0) ? b[7:4] : b[3:0];
    chk($sformatf("%s sample[%0d]", tag, ix), smp_q[ix], e);
    bi = -1;
    for (int k = 0; k < m; k++) if (bi < 0 && stb_cyc_q[k] != exp_t[k]) bi = k;
    ix = (bi < 0) ? m - 1 : bi;
    chk($sformatf("%s strobe_cycle[%0d]", tag, ix), stb_cyc_q[ix], exp_t[ix]);
    if (m > 1 && v.stall_idx < 0)
      chk({tag, " interval"}, stb_cyc_q[1] - stb_cyc_q[0], v.exp_period);
    if (v.stall_idx >= 0 && ack_cyc_q.size() > v.stall_idx && m > 2 * v.stall_idx)
      chk({tag, " stall_strobe"}, stb_cyc_q[2 * v.stall_idx], ack_cyc_q[v.stall_idx] + 1);
    if (done_cyc_q.size() > 0)
      chk({tag, " done_cycle"}, done_cyc_q[0], stb_cyc_q[stb_cyc_q.size() - 1]);
    stall_idx = -1;
    stall_len = 0;
  endtask

  vec_t vecs [6];

  initial begin
    int n, cnt_before;
    logic [3:0] frozen;
    vec_t rv;

    vecs[0] = '{16'h8000, 8'd1, 8'h80, 0, -1, 0,   32,   DIV,     0};
    vecs[1] = '{16'h8000, 8'd1, 8'hB3, 0, -1, 0,   32,   DIV * 8, 3};
    vecs[2] = '{16'h8000, 8'd1, 8'h80, 0,  2, 200, 32,   DIV,     0};
    vecs[3] = '{16'hFFF8, 8'd0, 8'h80, 1, -1, 0,   8192, DIV,     0};
    vecs[4] = '{16'h3000, 8'd1, 8'h07, 0, -1, 0,   0,    DIV,     0};
    vecs[5] = '{16'h1234, 8'd2, 8'hD1, 1, -1, 0,   64,   DIV * 2, 5};

    for (int i = 0; i < 65536; i++) mem_arr[i] = 8'd0;
    reset = 1'b1; dma_addr = 16'd0; dma_length = 8'd0; dma_ctrl = 8'd0;
    trig_we = 1'b0; trig_data = 8'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset mem_req", mem_req, 0);
    chk("reset mem_addr", mem_addr, 0);
    chk("reset mem_bank", mem_bank, 0);
    chk("reset sample", sample, 0);
    chk("reset sample_stb", sample_stb, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    @(posedge clk); #1;
    reset = 1'b0;

    for (int i = 0; i < 6; i++) run_block(vecs[i], $sformatf("vec%0d", i));

    rand_delay = 1'b1;
    for (int r = 0; r < 6; r++) begin
      rv.addr = 16'($urandom);
      rv.len  = 8'($urandom_range(1, 2));
      rv.exp_bank = int'($urandom_range(0, 7));
      rv.ctrl = {1'b1, 3'(rv.exp_bank), 2'b00, 2'($urandom_range(0, 1))};
      rv.pat = 1; rv.stall_idx = -1; rv.stall_len = 0;
      rv.exp_strobes = int'(rv.len) * 32;
      rv.exp_period = DIV << rv.ctrl[1:0];
      run_block(rv, $sformatf("rand%0d", r));
    end
    rand_delay = 1'b0;

    // stop mid-block after five samples
    mem_delay = 2;
    for (int i = 0; i < 16; i++) mem_arr[16'h4000 + i] = 8'($urandom);
    clear_logs();
    dma_addr = 16'h4000; dma_length = 8'd1; dma_ctrl = 8'h80;
    do_trig(8'h80, n);
    for (int i = 0; i < 400 && smp_q.size() < 5; i++) @(negedge clk);
    chk("stop five_samples_seen", smp_q.size() >= 5, 1);
    do_trig(8'h00, n);
    @(negedge clk);
    chk("stop busy", busy, 0);
    chk("stop mem_req", mem_req, 0);
    frozen = mem_arr[16'h4002][7:4];
    cnt_before = stb_cyc_q.size();
    repeat (40) @(negedge clk);
    chk("stop no_more_strobes", stb_cyc_q.size(), cnt_before);
    chk("stop no_done", done_cyc_q.size(), 0);
    chk("stop sample_frozen", sample, frozen);
    wait_mem_idle();

    // restart while a request is outstanding; the old answer carries 0xFF
    mem_delay = 10;
    for (int i = 0; i < 16; i++) mem_arr[16'h1000 + i] = 8'hFF;
    mem_arr[16'h2000] = 8'h3C;
    mem_arr[16'h2001] = 8'h71;
    clear_logs();
    dma_addr = 16'h1000; dma_length = 8'd1; dma_ctrl = 8'h80;
    do_trig(8'h80, n);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("restart req_pending", mem_req, 1);
    dma_addr = 16'h2000;
    do_trig(8'h80, n);
    for (int i = 0; i < 400 && smp_q.size() < 2; i++) @(negedge clk);
    chk("restart two_samples_seen", smp_q.size() >= 2, 1);
    if (smp_q.size() >= 2) begin
      chk("restart first_sample", smp_q[0], 4'h3);
      chk("restart second_sample", smp_q[1], 4'hC);
    end
    chk("restart req_count_ge2", req_addr_q.size() >= 2, 1);
    if (req_addr_q.size() >= 2) chk("restart new_req_addr", req_addr_q[1], 16'h2000);
    do_trig(8'h00, n);
    @(negedge clk);
    chk("restart stop busy", busy, 0);
    wait_mem_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
